// File: rtl/singleport_ram_pkg.sv
// Shared defaults and address-width helper for the single-port RAM.
package singleport_ram_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_RAM_DEPTH  = 1024;

    // ceil(log2(depth)), at least 1 for depth >= 2
    function automatic int unsigned calc_addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spram_core.sv
// Storage array with synchronous read register; no reset on either, so it maps to block RAM.
module spram_core #(
    parameter int unsigned data_width = 16,
    parameter int unsigned depth      = 1024,
    parameter int unsigned addr_width = 10
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wr_data,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/singleport_ram.sv
// Single-port RAM: range check, reset handling, valid pipeline and optional output register around spram_core.
module singleport_ram
    import singleport_ram_pkg::*;
#(
    parameter  int unsigned data_width = DEFAULT_DATA_WIDTH,
    parameter  int unsigned ram_depth  = DEFAULT_RAM_DEPTH,
    parameter  int unsigned out_reg    = 0,
    localparam int unsigned addr_width = calc_addr_width(ram_depth)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [data_width-1:0] data_ina,
    input  logic [addr_width-1:0] addra,
    input  logic                  we_a,
    output logic [data_width-1:0] data_outa,
    output logic                  rd_data_valid
);

    localparam logic [addr_width:0] depth_limit = (addr_width + 1)'(ram_depth);

    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [data_width-1:0] core_data;
    logic                  s1_valid;
    logic                  s1_zero;
    logic [data_width-1:0] s1_data;

    assign in_range = ({1'b0, addra} < depth_limit);
    assign wr_en    = reset & we_a & in_range;
    assign rd_en    = reset & ~we_a & in_range;

    spram_core #(
        .data_width (data_width),
        .depth      (ram_depth),
        .addr_width (addr_width)
    ) u_core (
        .clock   (clock),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addra),
        .wr_data (data_ina),
        .rd_data (core_data)
    );

    // The core read register is never reset; s1_zero masks it to zero after reset
    // and for out-of-range reads, and only changes on read cycles so writes hold it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b1;
        end else begin
            s1_valid <= ~we_a;
            if (!we_a) begin
                s1_zero <= ~in_range;
            end
        end
    end

    assign s1_data = s1_zero ? '0 : core_data;

    generate
        if (out_reg != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [data_width-1:0] s2_data;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign data_outa     = s2_data;
            assign rd_data_valid = s2_valid;
        end else begin : g_no_out_reg
            assign data_outa     = s1_data;
            assign rd_data_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_singleport_ram.sv
// Bench for singleport_ram: default config (latency 1) and depth 1000 with output register (latency 2).
module tb_singleport_ram;

    typedef struct {
        logic        v;
        logic [15:0] d;
        string       name;
    } exp_t;

    typedef struct {
        int          id;
        logic        w;
        logic [9:0]  a;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n [2];
    logic        we    [2];
    logic [9:0]  addr  [2];
    logic [15:0] din   [2];
    logic [15:0] dout  [2];
    logic        vld   [2];

    int checks = 0;
    int errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    vec_t tab[$];

    singleport_ram u_dut0 (
        .clock         (clk),
        .reset         (rst_n[0]),
        .data_ina      (din[0]),
        .addra         (addr[0]),
        .we_a          (we[0]),
        .data_outa     (dout[0]),
        .rd_data_valid (vld[0])
    );

    singleport_ram #(
        .data_width (16),
        .ram_depth  (1000),
        .out_reg    (1)
    ) u_dut1 (
        .clock         (clk),
        .reset         (rst_n[1]),
        .data_ina      (din[1]),
        .addra         (addr[1]),
        .we_a          (we[1]),
        .data_outa     (dout[1]),
        .rd_data_valid (vld[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input int id, input string name, input logic ev, input logic [15:0] ed);
        checks++;
        if (vld[id] !== ev || dout[id] !== ed) begin
            errors++;
            $display("FAIL dut%0d %s: got valid=%0b data=%h, expected valid=%0b data=%h",
                     id, name, vld[id], dout[id], ev, ed);
        end
    endtask

    task automatic check_pop(input int id, input int min_size);
        exp_t e;
        if (id == 0) begin
            if (sb0.size() < min_size) return;
            e = sb0.pop_front();
        end else begin
            if (sb1.size() < min_size) return;
            e = sb1.pop_front();
        end
        compare(id, e.name, e.v, e.d);
    endtask

    task automatic cycle(input int id, input logic w, input logic [9:0] a, input logic [15:0] d,
                         input logic ev, input logic [15:0] ed, input string name);
        exp_t e;
        @(negedge clk);
        check_pop(id, (id == 0) ? 1 : 2);
        we[id]   = w;
        addr[id] = a;
        din[id]  = d;
        e.v = ev;
        e.d = ed;
        e.name = name;
        if (id == 0) sb0.push_back(e);
        else         sb1.push_back(e);
    endtask

    task automatic drain(input int id);
        while ((id == 0) ? (sb0.size() > 0) : (sb1.size() > 0)) begin
            @(negedge clk);
            check_pop(id, 1);
        end
    endtask

    task automatic add_vec(input int id, input logic w, input logic [9:0] a, input logic [15:0] d,
                           input logic ev, input logic [15:0] ed, input string name);
        vec_t v;
        v.id = id; v.w = w; v.a = a; v.d = d; v.ev = ev; v.ed = ed; v.name = name;
        tab.push_back(v);
    endtask

    task automatic run_table(input int id);
        foreach (tab[k]) begin
            if (tab[k].id == id) begin
                cycle(id, tab[k].w, tab[k].a, tab[k].d, tab[k].ev, tab[k].ed, tab[k].name);
            end
        end
        drain(id);
    endtask

    initial begin
        // default config, entered after the reset-during-read sequence (last read: addr 4 = 0x003C)
        add_vec(0, 1'b1, 10'd7,    16'hA5A5, 1'b0, 16'h003C, "wr7_hold");
        add_vec(0, 1'b0, 10'd7,    16'h0000, 1'b1, 16'hA5A5, "rd7_after_wr");
        add_vec(0, 1'b0, 10'd5,    16'h0000, 1'b1, 16'h004B, "rd5");
        add_vec(0, 1'b1, 10'd5,    16'h1111, 1'b0, 16'h004B, "wr5_hold");
        add_vec(0, 1'b0, 10'd5,    16'h0000, 1'b1, 16'h1111, "rd5_new");
        add_vec(0, 1'b0, 10'd1023, 16'h0000, 1'b1, 16'h3BF1, "rd1023");
        add_vec(0, 1'b1, 10'd8,    16'h0000, 1'b0, 16'h3BF1, "wr8_hold");
        add_vec(0, 1'b0, 10'd8,    16'h0000, 1'b1, 16'h0000, "rd8_zero");
        add_vec(0, 1'b0, 10'd6,    16'h0000, 1'b1, 16'h005A, "rd6");
        // depth 1000, out_reg 1, entered straight from reset
        add_vec(1, 1'b1, 10'd999,  16'h0BEE, 1'b0, 16'h0000, "wr999");
        add_vec(1, 1'b1, 10'd1010, 16'h1234, 1'b0, 16'h0000, "wr1010_oor");
        add_vec(1, 1'b1, 10'd0,    16'h5555, 1'b0, 16'h0000, "wr0");
        add_vec(1, 1'b0, 10'd1010, 16'h0000, 1'b1, 16'h0000, "rd1010_oor");
        add_vec(1, 1'b0, 10'd999,  16'h0000, 1'b1, 16'h0BEE, "rd999");
        add_vec(1, 1'b0, 10'd0,    16'h0000, 1'b1, 16'h5555, "rd0");
        add_vec(1, 1'b1, 10'd999,  16'h7777, 1'b0, 16'h5555, "wr999_hold");
        add_vec(1, 1'b0, 10'd999,  16'h0000, 1'b1, 16'h7777, "rd999_new");
        add_vec(1, 1'b0, 10'd1005, 16'h0000, 1'b1, 16'h0000, "rd1005_oor");
        add_vec(1, 1'b1, 10'd3,    16'hABCD, 1'b0, 16'h0000, "wr3_hold_zero");
        add_vec(1, 1'b0, 10'd3,    16'h0000, 1'b1, 16'hABCD, "rd3");

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = '0;
            din[i]   = '0;
        end

        // 500 ns of reset with reads requested: outputs stay zero
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            compare(0, "reset_hold", 1'b0, 16'h0000);
            compare(1, "reset_hold", 1'b0, 16'h0000);
        end

        @(negedge clk);
        rst_n[0] = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            cycle(0, 1'b1, 10'(i), 16'(15 * i), 1'b0, 16'h0000, "fill_write");
        end
        for (int i = 0; i < 1024; i++) begin
            cycle(0, 1'b0, 10'(i), 16'h0000, 1'b1, 16'(15 * i), "stream_read");
        end
        drain(0);

        // reset arriving mid read stream, with a write attempted while held
        for (int i = 100; i < 110; i++) begin
            cycle(0, 1'b0, 10'(i), 16'h0000, 1'b1, 16'(15 * i), "pre_reset_read");
        end
        @(posedge clk);
        #3;
        rst_n[0] = 1'b0;
        #1;
        compare(0, "async_reset", 1'b0, 16'h0000);
        sb0.delete();
        we[0]   = 1'b1;
        addr[0] = 10'd3;
        din[0]  = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compare(0, "reset_write_block", 1'b0, 16'h0000);
        end
        we[0]    = 1'b0;
        rst_n[0] = 1'b1;
        cycle(0, 1'b0, 10'd3, 16'h0000, 1'b1, 16'h002D, "rd3_after_reset");
        cycle(0, 1'b0, 10'd4, 16'h0000, 1'b1, 16'h003C, "rd4_after_reset");
        drain(0);

        run_table(0);

        @(negedge clk);
        rst_n[1] = 1'b1;
        run_table(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
